game_ctrl: RTL and testbench
============================

# game_ctrl

Game-state controller for the Flappy Bird datapath, directly downstream of the pixel-level collision detector. Accumulates the per-pixel `collision` flag over each video frame and evaluates it once per frame. Sequences the game through idle, play, dying and game-over states, and keeps a two-digit BCD current score and best score. Drives the run/freeze enables consumed by the bird and pipe motion blocks and the score display.

## Interface
- DIE_FRAMES, 60, frames spent in DYING before GAME_OVER (1..255)
- Clk  in  1  50 MHz system clock; sole clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vsync-derived frame tick, synchronous to Clk; a frame boundary is its rising edge
- collision  in  1  registered per-pixel ball/pipe overlap flag from the collision stage
- flap  in  1  level from the flap key, synchronous to Clk
- pipe_passed  in  1  one-cycle pulse when the bird clears a pipe pair
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER
- run_en  out  1  high only in PLAY; motion blocks advance only when high
- game_over  out  1  high only in OVER
- score  out  8  BCD {tens, ones} of the current run
- best  out  8  BCD {tens, ones} best score since Reset
- new_best  out  1  high in OVER when the last run set a new best

## Operation
- frame_rise = frame_clk & ~frame_clk_q. The registers frame_clk_q and flap_q reset to 0. flap_rise is formed the same way.
- hit_latch is set by any cycle with collision=1. It is cleared on frame_rise. The frame verdict is hit = hit_latch | collision, so a collision on the frame_rise cycle counts toward the frame being closed.
- flap_pend is set on flap_rise and cleared on frame_rise. Verdict flap_go = flap_pend | flap_rise.
- State transitions occur only on frame_rise:
  - IDLE -> PLAY if flap_go. Entry clears score.
  - PLAY -> DYING if hit. Entry loads die_cnt = DIE_FRAMES-1.
  - DYING: if die_cnt == 0, go to OVER. Otherwise decrement die_cnt.
  - OVER -> IDLE if flap_go.
- Entering OVER compares score > best (BCD compare on tens, then ones).
  - If greater: best <= score and new_best <= 1.
  - Otherwise: new_best <= 0.
  - new_best is cleared on entering IDLE.
- Score counting:
  - score increments on any cycle with pipe_passed=1 while state==PLAY. This includes the frame_rise cycle that leaves PLAY.
  - ones wraps 9->0 with a carry into tens.
  - The score saturates at 99.
  - pipe_passed outside PLAY is ignored.
- collision outside PLAY still sets hit_latch but has no effect on state.

## Timing
- Reset values: state=IDLE, run_en=0, game_over=0, score=8'h00, best=8'h00, new_best=0, die_cnt=0, hit_latch=0, flap_pend=0.
- All outputs are registered or decoded directly from registered state.
- A state change becomes visible the cycle after the frame_rise cycle.
- Score updates are visible the cycle after pipe_passed.
- Latency from the first collision pixel to run_en=0 is at most 1 frame + 1 cycle.
- DYING lasts exactly DIE_FRAMES frame_rise events.
- Reset mid-run returns every register to its reset value on the next edge, including best.
- flap held high produces a single flap_rise. A new press requires flap to go low.

## Structure
- Shared package game_pkg:
  - typedef enum logic [1:0] game_state_t {IDLE, PLAY, DYING, OVER}
  - localparam BCD_MAX = 8'h99
- One sub-module, rise_detect, with ports (Clk, Reset, d, rise). It is instantiated for frame_clk and for flap.
- BCD increment and compare stay inline in game_ctrl.

## Test plan
- Reset, then flap pulse, then 1 frame_rise -> state=1, run_en=1, score=00 one cycle after the edge.
- In PLAY, 12 pipe_passed pulses -> score=8'h12. With score at 99, one more pipe_passed -> score stays 99.
- In PLAY, collision high for 3 pixels mid-frame -> state stays 1 until the next frame_rise, then state=2. Exactly DIE_FRAMES=60 further frame_rises -> state=3, game_over=1.
- Run ends with score 07 and best 00 -> best=07, new_best=1. Next run ends with score 05 -> best=07, new_best=0.
- collision and frame_rise in the same cycle during PLAY -> state=2. pipe_passed in that same cycle -> score still increments.
- Reset asserted during DYING -> all outputs return to reset values on the next cycle, and best=00.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the Flappy Bird game-state controller.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DYING = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level that is already synchronous to Clk.
module rise_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge Clk) begin
      if (Reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: frame-sampled collision/flap verdicts, IDLE/PLAY/DYING/OVER
// flow, and BCD current/best score keeping.
module game_ctrl
   import game_pkg::*;
#(
   parameter int DIE_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       collision,
   input  logic       flap,
   input  logic       pipe_passed,
   output logic [1:0] state,
   output logic       run_en,
   output logic       game_over,
   output logic [7:0] score,
   output logic [7:0] best,
   output logic       new_best
);

   game_state_t state_q, state_d;
   logic [7:0]  die_cnt_q, die_cnt_d;
   logic [7:0]  score_q, score_d;
   logic [7:0]  best_q, best_d;
   logic        new_best_q, new_best_d;
   logic        hit_latch_q, hit_latch_d;
   logic        flap_pend_q, flap_pend_d;

   logic frame_rise, flap_rise;
   logic hit, flap_go, score_gt;

   rise_detect u_frame_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (frame_clk),
      .rise  (frame_rise)
   );

   rise_detect u_flap_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (flap),
      .rise  (flap_rise)
   );

   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      logic [7:0] r;
      if (s == BCD_MAX)         r = s;
      else if (s[3:0] == 4'h9)  r = {s[7:4] + 4'h1, 4'h0};
      else                      r = {s[7:4], s[3:0] + 4'h1};
      return r;
   endfunction

   assign hit      = hit_latch_q | collision;
   assign flap_go  = flap_pend_q | flap_rise;
   assign score_gt = (score_q[7:4] > best_q[7:4]) ||
                     ((score_q[7:4] == best_q[7:4]) &&
                      (score_q[3:0] > best_q[3:0]));

   always_comb begin
      state_d     = state_q;
      die_cnt_d   = die_cnt_q;
      score_d     = score_q;
      best_d      = best_q;
      new_best_d  = new_best_q;
      hit_latch_d = frame_rise ? 1'b0 : (hit_latch_q | collision);
      flap_pend_d = frame_rise ? 1'b0 : (flap_pend_q | flap_rise);

      // A pipe cleared on the frame that ends PLAY still scores
      if (state_q == PLAY && pipe_passed) score_d = bcd_inc(score_q);

      if (frame_rise) begin
         unique case (state_q)
            IDLE: begin
               if (flap_go) begin
                  state_d = PLAY;
                  score_d = 8'h00;
               end
            end
            PLAY: begin
               if (hit) begin
                  state_d   = DYING;
                  die_cnt_d = 8'(DIE_FRAMES - 1);
               end
            end
            DYING: begin
               if (die_cnt_q == 8'd0) begin
                  state_d    = OVER;
                  new_best_d = score_gt;
                  if (score_gt) best_d = score_q;
               end else begin
                  die_cnt_d = die_cnt_q - 8'd1;
               end
            end
            OVER: begin
               if (flap_go) begin
                  state_d    = IDLE;
                  new_best_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         die_cnt_q   <= 8'd0;
         score_q     <= 8'h00;
         best_q      <= 8'h00;
         new_best_q  <= 1'b0;
         hit_latch_q <= 1'b0;
         flap_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         die_cnt_q   <= die_cnt_d;
         score_q     <= score_d;
         best_q      <= best_d;
         new_best_q  <= new_best_d;
         hit_latch_q <= hit_latch_d;
         flap_pend_q <= flap_pend_d;
      end
   end

   assign state     = state_q;
   assign run_en    = (state_q == PLAY);
   assign game_over = (state_q == OVER);
   assign score     = score_q;
   assign best      = best_q;
   assign new_best  = new_best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game runs plus random play against a
// decimal-score reference model.
module tb_game_ctrl;

   localparam int DIE = 60;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk, collision, flap, pipe_passed;
   logic [1:0] state;
   logic       run_en, game_over, new_best;
   logic [7:0] score, best;

   game_ctrl #(.DIE_FRAMES(DIE)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .collision   (collision),
      .flap        (flap),
      .pipe_passed (pipe_passed),
      .state       (state),
      .run_en      (run_en),
      .game_over   (game_over),
      .score       (score),
      .best        (best),
      .new_best    (new_best)
   );

   always #10 Clk = ~Clk;

   int vecs = 0;
   int errs = 0;

   // Model: state as 0..3, scores as plain decimal integers
   int m_st, m_left, m_score, m_best;
   bit m_nb, m_hl, m_fp, m_pf, m_pfl;

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic model_step();
      bit fr, flr, hitv, go;
      if (Reset) begin
         m_st = 0; m_left = 0; m_score = 0; m_best = 0;
         m_nb = 0; m_hl = 0; m_fp = 0; m_pf = 0; m_pfl = 0;
         return;
      end
      fr   = frame_clk && !m_pf;
      flr  = flap && !m_pfl;
      hitv = m_hl || collision;
      go   = m_fp || flr;
      if (m_st == 1 && pipe_passed && m_score < 99) m_score++;
      if (fr) begin
         if (m_st == 0) begin
            if (go) begin m_st = 1; m_score = 0; end
         end else if (m_st == 1) begin
            if (hitv) begin m_st = 2; m_left = DIE; end
         end else if (m_st == 2) begin
            m_left--;
            if (m_left == 0) begin
               m_st = 3;
               m_nb = (m_score > m_best);
               if (m_nb) m_best = m_score;
            end
         end else begin
            if (go) begin m_st = 0; m_nb = 0; end
         end
      end
      m_hl  = fr ? 1'b0 : (m_hl || collision);
      m_fp  = fr ? 1'b0 : (m_fp || flr);
      m_pf  = frame_clk;
      m_pfl = flap;
   endtask

   task automatic check(input string tag);
      logic [20:0] got, exp;
      exp = {2'(m_st), (m_st == 1), (m_st == 3), bcd(m_score),
             bcd(m_best), m_nb};
      got = {state, run_en, game_over, score, best, new_best};
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge Clk);
      model_step();
      #1;
      check(tag);
   endtask

   task automatic frame_pulse(input string tag);
      frame_clk = 1'b1;
      tick(tag);
      frame_clk = 1'b0;
      repeat (3) tick(tag);
   endtask

   task automatic press(input string tag);
      flap = 1'b1;
      tick(tag);
      flap = 1'b0;
      tick(tag);
   endtask

   task automatic pipes(input int n, input string tag);
      repeat (n) begin
         pipe_passed = 1'b1;
         tick(tag);
         pipe_passed = 1'b0;
         tick(tag);
      end
   endtask

   task automatic die_out(input string tag);
      for (int i = 0; i < DIE - 1; i++) frame_pulse(tag);
      chk("dying_last", {6'd0, state}, 8'd2);
      frame_pulse(tag);
      chk("over_state", {6'd0, state}, 8'd3);
      chk("over_flag", {7'd0, game_over}, 8'd1);
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; collision = 1'b0;
      flap = 1'b0; pipe_passed = 1'b0;
      tick("reset");
      chk("reset_state", {6'd0, state}, 8'd0);
      Reset = 1'b0;
      tick("idle");

      // Run 1: score 07, collision mid-frame
      press("press1");
      frame_pulse("start1");
      chk("play_state", {6'd0, state}, 8'd1);
      chk("play_run_en", {7'd0, run_en}, 8'd1);
      chk("play_score0", score, 8'h00);
      pipes(7, "pipes7");
      collision = 1'b1;
      repeat (3) tick("coll3");
      collision = 1'b0;
      repeat (2) tick("coll_wait");
      chk("coll_still_play", {6'd0, state}, 8'd1);
      frame_pulse("coll_frame");
      chk("dying_state", {6'd0, state}, 8'd2);
      die_out("die1");
      chk("best07", best, 8'h07);
      chk("new_best1", {7'd0, new_best}, 8'd1);

      // Held flap yields one rise: OVER->IDLE only, no re-start
      flap = 1'b1;
      tick("hold");
      frame_pulse("to_idle");
      chk("idle_after_over", {6'd0, state}, 8'd0);
      frame_pulse("held_no_start");
      chk("held_stays_idle", {6'd0, state}, 8'd0);
      flap = 1'b0;
      tick("release");

      // Run 2: score 05 with the last pipe on the fatal frame edge
      press("press2");
      frame_pulse("start2");
      pipes(4, "pipes4");
      collision = 1'b1; frame_clk = 1'b1; pipe_passed = 1'b1;
      tick("coll_on_edge");
      collision = 1'b0; frame_clk = 1'b0; pipe_passed = 1'b0;
      chk("edge_dying", {6'd0, state}, 8'd2);
      chk("edge_score", score, 8'h05);
      tick("after_edge");
      die_out("die2");
      chk("best_kept", best, 8'h07);
      chk("new_best0", {7'd0, new_best}, 8'd0);

      // Run 3: BCD carry and saturation, then reset while dying
      press("press3a");
      frame_pulse("to_idle3");
      press("press3b");
      frame_pulse("start3");
      chk("score_cleared", score, 8'h00);
      pipes(12, "pipes12");
      chk("score12", score, 8'h12);
      pipes(87, "pipes99");
      chk("score99", score, 8'h99);
      pipes(1, "sat");
      chk("score_sat", score, 8'h99);
      collision = 1'b1;
      tick("coll3b");
      collision = 1'b0;
      frame_pulse("to_dying3");
      frame_pulse("dying3");
      Reset = 1'b1;
      tick("mid_reset");
      Reset = 1'b0;
      chk("rst_state", {6'd0, state}, 8'd0);
      chk("rst_best", best, 8'h00);
      chk("rst_score", score, 8'h00);
      tick("post_reset");

      // Random play
      for (int i = 0; i < 6000; i++) begin
         frame_clk   = ((i % 16) < 2);
         collision   = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) flap = ~flap;
         pipe_passed = ($urandom_range(0, 4) == 0);
         Reset       = ($urandom_range(0, 2999) == 0);
         tick("random");
      end
      Reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
